// File: rtl/urv_trap_ctrl.sv
// urv_trap_ctrl: machine-mode trap controller for a small RISC-V core.
// Tracks exception/interrupt entry and MRET return, owns mstatus.MIE/MPIE,
// mie, mip, mepc and mcause, and issues a one-cycle redirect strobe.
// Build option: define URV_TIMER_IRQ_EN to enable the timer interrupt
// (mip/mie bit 7); without it timer_irq_i is ignored and bit 7 reads 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal execution; traps and MRET are accepted on commit
// ENTER   | redirect to the trap vector is being issued (one cycle)
// HANDLER | inside the trap handler; interrupts masked, MRET returns

module urv_trap_ctrl #(
   parameter logic [31:0] g_trap_vector = 32'h0000_0008
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        x_stall_i,
   input  logic        x_kill_i,
   input  logic [31:0] x_pc_i,
   input  logic        x_exception_i,
   input  logic [3:0]  x_exception_cause_i,
   input  logic        x_is_mret_i,
   input  logic        x_csr_write_i,
   input  logic [11:0] x_csr_sel_i,
   input  logic [31:0] x_csr_write_value_i,
   input  logic        irq_i,
   input  logic        timer_irq_i,
   output logic        x_trap_o,
   output logic [31:0] x_trap_pc_o,
   output logic [31:0] csr_mstatus_o,
   output logic [31:0] csr_mip_o,
   output logic [31:0] csr_mie_o,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_mcause_o
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      ENTER   = 2'd1,
      HANDLER = 2'd2
   } state_t;

   state_t      state;
   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic        mie_meie;
   logic        mie_mtie;
   logic        mip_meip;
   logic        mip_mtip;
   logic [31:0] mepc;
   logic [31:0] mcause;

   logic        commit;
   logic        ext_pending;
   logic        tmr_pending;
   logic        take_exc;
   logic        take_int;
   logic        take_trap;
   logic        take_mret;
   logic        take_csr;
   logic        timer_src;
   logic [31:0] trap_cause;

`ifdef URV_TIMER_IRQ_EN
   assign timer_src = timer_irq_i;
`else
   logic timer_unused;
   assign timer_unused = timer_irq_i;
   assign timer_src    = 1'b0;
`endif

   // ENTER is the redirect cycle: the execute-stage instruction there is the
   // one being flushed, so it can neither trap, return nor write a CSR.
   assign commit      = !x_stall_i && !x_kill_i && (state != ENTER);
   assign ext_pending = mip_meip && mie_meie;
   assign tmr_pending = mip_mtip && mie_mtie;
   assign take_exc    = commit && x_exception_i;
   assign take_int    = commit && (state == RUN) && mstatus_mie && (ext_pending || tmr_pending);
   assign take_trap   = take_exc || take_int;
   assign take_mret   = commit && x_is_mret_i && !take_trap;
   assign take_csr    = commit && x_csr_write_i && !take_trap && !take_mret;

   // mcause priority: synchronous exception, then external, then timer
   always_comb begin
      trap_cause = 32'h8000_0007;
      if (take_exc) begin
         trap_cause = {28'b0, x_exception_cause_i};
      end else if (ext_pending) begin
         trap_cause = 32'h8000_000B;
      end
   end

   // pending-interrupt register samples the levels every cycle, stalled or not
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mip_meip <= 1'b0;
         mip_mtip <= 1'b0;
      end else begin
         mip_meip <= irq_i;
         mip_mtip <= timer_src;
      end
   end

   // trap FSM, redirect strobe and the writable CSR state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= RUN;
         x_trap_o     <= 1'b0;
         x_trap_pc_o  <= 32'h0;
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_meie     <= 1'b0;
         mie_mtie     <= 1'b0;
         mepc         <= 32'h0;
         mcause       <= 32'h0;
      end else begin
         x_trap_o <= 1'b0;
         if (state == ENTER) begin
            state <= HANDLER;
         end

         if (take_trap) begin
            state       <= ENTER;
            x_trap_o    <= 1'b1;
            x_trap_pc_o <= g_trap_vector;
            mepc        <= x_pc_i;
            mcause      <= trap_cause;
            mstatus_mie <= 1'b0;
            // a nested exception in the handler must not lose the saved MIE
            if (state == RUN) begin
               mstatus_mpie <= mstatus_mie;
            end
         end else if (take_mret) begin
            state        <= RUN;
            x_trap_o     <= 1'b1;
            x_trap_pc_o  <= mepc;
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (take_csr) begin
            case (x_csr_sel_i)
               CSR_MSTATUS: begin
                  mstatus_mie  <= x_csr_write_value_i[3];
                  mstatus_mpie <= x_csr_write_value_i[7];
               end
               CSR_MIE: begin
                  mie_meie <= x_csr_write_value_i[11];
`ifdef URV_TIMER_IRQ_EN
                  mie_mtie <= x_csr_write_value_i[7];
`endif
               end
               CSR_MEPC:   mepc   <= {x_csr_write_value_i[31:2], 2'b00};
               CSR_MCAUSE: mcause <= x_csr_write_value_i;
               default: ;
            endcase
         end
      end
   end

   assign csr_mstatus_o = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
   assign csr_mip_o     = {20'b0, mip_meip, 3'b0, mip_mtip, 7'b0};
   assign csr_mie_o     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
   assign csr_mepc_o    = mepc;
   assign csr_mcause_o  = mcause;

endmodule
